// File: rtl/classificador_pesagem.sv
// classificador_pesagem: vehicle weighing classifier.
// Averages N_AMOSTRAS weight samples for one vehicle, then classifies the
// mean into one of three categories (c1/c2/c3) and raises E on an axle-code
// problem or per-axle overweight.
// Optional feature: define CLASSIF_CONTADOR_EN to add saturating 16-bit
// counters of completed output handshakes per category and per E=1.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both 1. The producer holds its data stable while
// valid=1 and ready=0; a ready without valid has no effect.
// FSM state is exposed on the estado output (IDLE=0, ACUMULA=1, DECIDE=2,
// SAIDA=3).
module classificador_pesagem #(
    parameter int PESO_W     = 4,
    parameter int EIXO_W     = 2,
    parameter int N_AMOSTRAS = 4,
    parameter int LIM1       = 5,
    parameter int LIM2       = 10,
    parameter int LIM_EIXO   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PESO_W-1:0] p,
    input  logic [EIXO_W-1:0] e,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              cancel,
    output logic              c1,
    output logic              c2,
    output logic              c3,
    output logic              E,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        estado
`ifdef CLASSIF_CONTADOR_EN
    ,
    output logic [15:0]       cont_c1,
    output logic [15:0]       cont_c2,
    output logic [15:0]       cont_c3,
    output logic [15:0]       cont_e
`endif
);

    // Sum carries 4 extra bits so 16 full-scale samples can never overflow.
    localparam int SUM_W = PESO_W + 4;
    localparam int CNT_W = 5;
    localparam int SH    = $clog2(N_AMOSTRAS);
    localparam int PW    = PESO_W + EIXO_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACUMULA = 2'd1,
        DECIDE  = 2'd2,
        SAIDA   = 2'd3
    } state_t;

    state_t             state;
    logic [SUM_W-1:0]   sum;
    logic [CNT_W-1:0]   count;
    logic [EIXO_W-1:0]  e_ref;
    logic               err_eixo;

    logic               accept;
    logic               last_sample;
    logic [SUM_W-1:0]   media;
    logic [PW-1:0]      lim_prod;
    logic               d_c1;
    logic               d_c2;
    logic               d_c3;
    logic               d_e;

    assign in_ready = (state == IDLE) || (state == ACUMULA);
    assign estado   = state;

    // Cancel wins over an offered sample in ACUMULA, so the sample is dropped.
    assign accept      = in_valid && in_ready && !(cancel && state == ACUMULA);
    assign last_sample = (state == IDLE) ? (N_AMOSTRAS == 1)
                                         : ((count + CNT_W'(1)) == CNT_W'(N_AMOSTRAS));

    // Decision logic: truncated mean, per-axle limit and category thresholds.
    always_comb begin
        media    = sum >> SH;
        lim_prod = PW'(e_ref) * PW'(LIM_EIXO);
        d_e      = (e_ref == '0) || err_eixo || (32'(media) > 32'(lim_prod));
        d_c1     = 1'b0;
        d_c2     = 1'b0;
        d_c3     = 1'b0;
        if (32'(media) <= 32'(LIM1))
            d_c1 = 1'b1;
        else if (32'(media) <= 32'(LIM2))
            d_c2 = 1'b1;
        else
            d_c3 = 1'b1;
    end

    // Main FSM: accumulation, decision and result hold with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sum       <= '0;
            count     <= '0;
            e_ref     <= '0;
            err_eixo  <= 1'b0;
            c1        <= 1'b0;
            c2        <= 1'b0;
            c3        <= 1'b0;
            E         <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sum      <= SUM_W'(p);
                        e_ref    <= e;
                        count    <= CNT_W'(1);
                        err_eixo <= 1'b0;
                        state    <= last_sample ? DECIDE : ACUMULA;
                    end
                end
                ACUMULA: begin
                    if (cancel) begin
                        sum      <= '0;
                        count    <= '0;
                        err_eixo <= 1'b0;
                        state    <= IDLE;
                    end else if (accept) begin
                        sum   <= sum + SUM_W'(p);
                        count <= count + CNT_W'(1);
                        if (e != e_ref)
                            err_eixo <= 1'b1;
                        if (last_sample)
                            state <= DECIDE;
                    end
                end
                DECIDE: begin
                    if (cancel) begin
                        sum      <= '0;
                        count    <= '0;
                        err_eixo <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        c1        <= d_c1;
                        c2        <= d_c2;
                        c3        <= d_c3;
                        E         <= d_e;
                        out_valid <= 1'b1;
                        state     <= SAIDA;
                    end
                end
                SAIDA: begin
                    // Results stay put after the handshake until the next decision.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        sum       <= '0;
                        count     <= '0;
                        err_eixo  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CLASSIF_CONTADOR_EN
    // Saturating counts of completed output handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cont_c1 <= '0;
            cont_c2 <= '0;
            cont_c3 <= '0;
            cont_e  <= '0;
        end else if (state == SAIDA && out_ready) begin
            if (c1 && cont_c1 != 16'hFFFF) cont_c1 <= cont_c1 + 16'd1;
            if (c2 && cont_c2 != 16'hFFFF) cont_c2 <= cont_c2 + 16'd1;
            if (c3 && cont_c3 != 16'hFFFF) cont_c3 <= cont_c3 + 16'd1;
            if (E  && cont_e  != 16'hFFFF) cont_e  <= cont_e  + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_classificador_pesagem.sv
// Directed testbench for classificador_pesagem (default parameters).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_classificador_pesagem;

    logic       clk;
    logic       rst;
    logic [3:0] p;
    logic [1:0] e;
    logic       in_valid;
    logic       in_ready;
    logic       cancel;
    logic       c1;
    logic       c2;
    logic       c3;
    logic       E;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] estado;

    int n_cmp  = 0;
    int n_fail = 0;

    classificador_pesagem dut (
        .clk       (clk),
        .rst       (rst),
        .p         (p),
        .e         (e),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cancel    (cancel),
        .c1        (c1),
        .c2        (c2),
        .c3        (c3),
        .E         (E),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .estado    (estado)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // {c1,c2,c3,E,out_valid}
    function automatic logic [31:0] res5();
        return {27'd0, c1, c2, c3, E, out_valid};
    endfunction

    // driver: one sample per call, called at a falling edge
    task automatic drive_sample(input logic [3:0] pv, input logic [1:0] ev);
        in_valid = 1'b1;
        p        = pv;
        e        = ev;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // four samples, then check the DECIDE cycle and the registered result
    task automatic run_vehicle(input string tag, input logic [15:0] ps, input logic [7:0] es,
                               input logic [4:0] exp_res);
        for (int i = 0; i < 4; i++)
            drive_sample(ps[i*4 +: 4], es[i*2 +: 2]);
        chk({tag, "_decide_state"}, 32'(estado), 32'd2);
        chk({tag, "_decide_noval"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_result"}, res5(), 32'(exp_res));
        chk({tag, "_saida_inrdy"}, 32'(in_ready), 32'd0);
    endtask

    task automatic handshake(input string tag, input logic [3:0] exp_cat);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_hs_retain"}, res5(), 32'({exp_cat, 1'b0}));
        chk({tag, "_hs_idle"}, 32'({estado, in_ready}), 32'({2'd0, 1'b1}));
    endtask

    initial begin
        rst = 1'b1; p = '0; e = '0; in_valid = 1'b0; cancel = 1'b0; out_ready = 1'b0;
        #3;
        chk("reset_outputs", res5(), 32'd0);
        chk("reset_state", 32'({estado, in_ready}), 32'({2'd0, 1'b1}));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 4 x p=4, e=1: mean 4 -> c1, E=0
        drive_sample(4'd4, 2'd1);
        chk("acum_state", 32'({estado, in_ready}), 32'({2'd1, 1'b1}));
        drive_sample(4'd4, 2'd1);
        drive_sample(4'd4, 2'd1);
        drive_sample(4'd4, 2'd1);
        chk("v1_decide_state", 32'(estado), 32'd2);
        chk("v1_decide_noval", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("v1_result", res5(), 32'b10001);
        handshake("v1", 4'b1000);

        // p=8,8,9,9 e=2: sum 34, mean 8 -> c2, E=0
        run_vehicle("v2", {4'd9, 4'd9, 4'd8, 4'd8}, {2'd2, 2'd2, 2'd2, 2'd2}, 5'b01001);
        handshake("v2", 4'b0100);

        // 4 x p=15 e=2: mean 15 > 10 -> c3; 15 > 2*5 -> E; held 5 cycles
        run_vehicle("v3", {4'd15, 4'd15, 4'd15, 4'd15}, {2'd2, 2'd2, 2'd2, 2'd2}, 5'b00111);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; p = 4'd1; e = 2'd1; cancel = 1'b1;
            @(negedge clk);
            chk("v3_stall_out", res5(), 32'b00111);
            chk("v3_stall_rdy", 32'({estado, in_ready}), 32'({2'd3, 1'b0}));
        end
        in_valid = 1'b0; cancel = 1'b0;
        handshake("v3", 4'b0011);

        // axle mismatch e=2,2,3,2, p=4: c1 with E
        run_vehicle("v4", {4'd4, 4'd4, 4'd4, 4'd4}, {2'd2, 2'd3, 2'd2, 2'd2}, 5'b10011);
        handshake("v4", 4'b1001);

        // axle code 0: c1 with E
        run_vehicle("v5", {4'd4, 4'd4, 4'd4, 4'd4}, {2'd0, 2'd0, 2'd0, 2'd0}, 5'b10011);
        handshake("v5", 4'b1001);

        // two samples, then cancel with a sample offered on the same edge
        drive_sample(4'd15, 2'd0);
        drive_sample(4'd15, 2'd0);
        cancel = 1'b1; in_valid = 1'b1; p = 4'd15; e = 2'd0;
        @(negedge clk);
        cancel = 1'b0; in_valid = 1'b0;
        chk("cancel_idle", 32'(estado), 32'd0);
        // 4 x p=12 e=3: mean 12 -> c3; 12 <= 15 -> E=0
        run_vehicle("v6", {4'd12, 4'd12, 4'd12, 4'd12}, {2'd3, 2'd3, 2'd3, 2'd3}, 5'b00101);
        handshake("v6", 4'b0010);

        // cancel during DECIDE: no result, previous outputs retained
        for (int i = 0; i < 4; i++)
            drive_sample(4'd2, 2'd1);
        chk("v7_decide_state", 32'(estado), 32'd2);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("v7_cancel_idle", 32'(estado), 32'd0);
        @(negedge clk);
        chk("v7_no_result", res5(), 32'b00100);

        // asynchronous reset mid-ACUMULA
        drive_sample(4'd15, 2'd2);
        drive_sample(4'd15, 2'd2);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_out", res5(), 32'd0);
        chk("rst_async_state", 32'({estado, in_ready}), 32'({2'd0, 1'b1}));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        // fresh vehicle after reset: partial sum must be gone
        run_vehicle("v8", {4'd4, 4'd4, 4'd4, 4'd4}, {2'd1, 2'd1, 2'd1, 2'd1}, 5'b10001);
        handshake("v8", 4'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/classificador_pesagem.md
CLASSIFICADOR_PESAGEM -- requirements
Module: classificador_pesagem

Interface
REQ-001 Parameter PESO_W, default 4: width of weight sample p.
REQ-002 Parameter EIXO_W, default 2: width of axle code e.
REQ-003 Parameter N_AMOSTRAS, default 4: samples averaged per vehicle; legal values are 1, 2, 4, 8 and 16.
REQ-004 Parameter LIM1, default 5: highest mean weight for category c1.
REQ-005 Parameter LIM2, default 10: highest mean weight for category c2.
REQ-006 Parameter LIM_EIXO, default 5: maximum mean weight per axle.
REQ-007 Port clk, input, 1: single clock; all state changes occur on its rising edge.
REQ-008 Port rst, input, 1: asynchronous, active-high reset.
REQ-009 Port p, input, PESO_W: weight sample.
REQ-010 Port e, input, EIXO_W: axle count code.
REQ-011 Port in_valid, input, 1: p and e are valid.
REQ-012 Port in_ready, output, 1: block accepts a sample.
REQ-013 Port cancel, input, 1: synchronous abort of the current vehicle.
REQ-014 Ports c1, c2, c3, output, 1 each: one-hot category result.
REQ-015 Port E, output, 1: error or overweight flag.
REQ-016 Port out_valid, output, 1: result valid.
REQ-017 Port out_ready, input, 1: consumer takes the result.

Function
REQ-018 The FSM SHALL have four states: IDLE, ACUMULA, DECIDE and SAIDA.
REQ-019 in_ready SHALL be 1 in IDLE and ACUMULA, and 0 in DECIDE and SAIDA.
REQ-020 A sample SHALL be accepted on any edge where in_valid and in_ready are both 1.
REQ-021 On the first accept, the FSM SHALL move IDLE to ACUMULA, load sum with p, latch e as e_ref and set count to 1.
REQ-022 Each subsequent accept SHALL add p to sum, increment count, and set err_eixo if e differs from e_ref.
REQ-023 sum SHALL be PESO_W+4 bits wide and SHALL never overflow.
REQ-024 The accept that brings count to N_AMOSTRAS SHALL move the FSM to DECIDE; with N_AMOSTRAS=1 the first accept goes directly from IDLE to DECIDE.
REQ-025 In DECIDE, mean M SHALL be computed as sum shifted right by log2(N_AMOSTRAS), truncating.
REQ-026 In DECIDE, E SHALL be set if e_ref is 0, or err_eixo is 1, or M > e_ref*LIM_EIXO; the product SHALL be computed at PESO_W+EIXO_W bits.
REQ-027 In DECIDE, the category SHALL be c1 if M <= LIM1, otherwise c2 if M <= LIM2, otherwise c3; exactly one of c1, c2, c3 SHALL be 1, including when E is 1.
REQ-028 The edge leaving DECIDE SHALL register c1, c2, c3 and E, set out_valid to 1 and enter SAIDA; out_valid is therefore high one cycle after the last-sample accept edge.
REQ-029 In SAIDA, out_valid and the results SHALL be held stable until an edge with out_ready=1, which SHALL clear out_valid and return the FSM to IDLE.
REQ-030 c1, c2, c3 and E SHALL retain their last value after the handshake completes, until the next result is registered.
REQ-031 cancel=1 in ACUMULA or DECIDE SHALL clear sum, count and err_eixo and return the FSM to IDLE; any sample offered on that edge SHALL be discarded.
REQ-032 cancel SHALL be ignored in IDLE and in SAIDA.
REQ-033 in_valid while in_ready=0 SHALL have no effect.

Reset
REQ-034 rst=1 SHALL immediately force state IDLE, sum=0, count=0, e_ref=0, err_eixo=0, c1=c2=c3=0, E=0 and out_valid=0, independent of clk.
REQ-035 Reset asserted mid-vehicle or during SAIDA SHALL discard all partial or pending results.

Configuration
REQ-036 With CLASSIF_CONTADOR_EN defined, the block SHALL add outputs cont_c1, cont_c2, cont_c3 and cont_e (16 bits each): saturating counts of completed output handshakes per category and per E=1, cleared by rst.
REQ-037 Without CLASSIF_CONTADOR_EN, these ports and their counters SHALL NOT exist.

Verification (default parameters)
REQ-038 Four samples of p=4 with e=1, then out_ready=1 -> out_valid one cycle after the 4th accept; c1=1, E=0.
REQ-039 Samples p=8,8,9,9 with e=2 -> M=8; c2=1, E=0.
REQ-040 Samples p=15 x4 with e=2 -> M=15 > 10; c3=1, E=1.
REQ-041 Samples with e=2,2,3,2 and p=4 -> c1=1, E=1 (axle mismatch); separately, e=0 with p=4 x4 -> E=1.
REQ-042 cancel asserted after 2 samples, then 4 samples of p=12 with e=3 -> M=12, c3=1, E=0; the first 2 samples have no influence.
REQ-043 out_ready held at 0 for 5 cycles in SAIDA -> outputs stable and in_ready=0 throughout; rst pulsed mid-ACUMULA -> all outputs 0 immediately.
